mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage data-memory controller between the EX/MEM pipeline register and the MEM/WB register.
- Turns MemRead/MemWrite from the pipeline into a request/ready handshake on a multi-cycle data-memory bus.
- Formats load data (byte/half/word, sign or zero extended) and drives ReadDataFromMem_MEM into MEM/WB.
- Raises MemStall to freeze the upstream stages and MEM/WB until the access completes.

Parameters:
- TIMEOUT, 16: maximum cycles in BUSY before the access is abandoned with BusErr; 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- Clk  in  1  sole clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- MemRead_MEM  in  1  load in MEM stage.
- MemWrite_MEM  in  1  store in MEM stage.
- MemSize_MEM  in  2  00 word, 01 half, 10 byte, 11 reserved.
- MemSigned_MEM  in  1  1 = sign-extend loads.
- Address_MEM  in  ADDR_W  byte address (ALU result).
- WriteData_MEM  in  32  store data, right-justified.
- DMemReq  out  1  bus request.
- DMemWe  out  1  1 = write.
- DMemAddr  out  ADDR_W  word-aligned address (low 2 bits 0).
- DMemBE  out  4  byte enables.
- DMemWData  out  32  lane-replicated store data.
- DMemReady  in  1  bus completion; read data valid the same cycle.
- DMemRData  in  32  read word.
- ReadDataFromMem_MEM  out  32  formatted load result.
- MemStall  out  1  freeze pipeline.
- MisalignExc  out  1  misaligned access flag.
- BusErr  out  1  timeout flag, one-cycle pulse.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE immediately; timeout counter cleared.
  - All outputs 0, including DMemReq, MemStall and ReadDataFromMem_MEM.
  - A request in flight is abandoned at once; the bus must tolerate DMemReq dropping.
- Access decode:
  - valid = MemRead_MEM | MemWrite_MEM.
  - Write has priority if both are set: treated as a store.
  - misaligned = (size=word & addr[1:0]≠0) | (size=half & addr[0]) | size=11.
- IDLE:
  - valid & !misaligned: MemStall=1 combinationally. Addr, BE, WData and We are registered; next state BUSY.
  - valid & misaligned: MisalignExc=1 combinationally, MemStall=0, no bus request, stay IDLE.
  - !valid: all bus outputs 0.
- BUSY:
  - DMemReq=1; DMemAddr, DMemBE, DMemWData and DMemWe are held stable from registers. MemStall=1.
  - DMemReady=1 in this cycle: loads capture the formatted DMemRData into the ReadDataFromMem_MEM register; next state DONE.
  - Otherwise the counter increments. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without ready: go to DONE, pulse BusErr for that DONE cycle, leave ReadDataFromMem_MEM unchanged.
- DONE:
  - MemStall=0 and DMemReq=0, so the pipeline advances at this edge.
  - Counter cleared; next state IDLE.
- Latency: an access takes 3 cycles at minimum (IDLE, BUSY with ready, DONE), plus one cycle per wait cycle.
- Ready in the same cycle as the request is not possible: the request is only visible from BUSY.
- The instruction in MEM during DONE is the one that completed, so it is never reissued.
- Store byte enables:
  - word: 1111.
  - half: addr[1]=0 → 0011, addr[1]=1 → 1100.
  - byte: 0001 shifted left by addr[1:0].
- Store data: half → {2{wd[15:0]}}; byte → {4{wd[7:0]}}; word → wd.
- Load format (little-endian):
  - byte: lane selected by addr[1:0].
  - half: lane selected by addr[1].
  - Extended to 32 bits by MemSigned_MEM; word loads pass through unchanged.
- ReadDataFromMem_MEM holds its value between loads; stores do not modify it.
- DMemReady while not in BUSY is ignored.

Decomposition:
- Package mem_pkg holds:
  - size encodings MEM_WORD=2'b00, MEM_HALF=2'b01, MEM_BYTE=2'b10;
  - state encodings IDLE, BUSY, DONE;
  - byte-enable constants.
- One combinational sub-module, mem_load_align: lane select plus sign/zero extension. It is reused by the writeback mux if byte loads are ever moved to WB.

Test Plan:
- Word load at 0x100, ready after 2 wait cycles, DMemRData=0xDEADBEEF → DMemAddr=0x100, BE=1111, MemStall high 4 cycles, ReadDataFromMem_MEM=0xDEADBEEF in DONE.
- Signed byte load at 0x103, DMemRData=0x80FF0000 → result 0xFFFFFF80; unsigned gives 0x00000080.
- Half store at 0x202 with WriteData=0x1234ABCD → DMemAddr=0x200, BE=1100, WData=0xABCDABCD, DMemWe=1, ReadDataFromMem_MEM unchanged.
- Word load at 0x101 → MisalignExc=1, MemStall=0, DMemReq never asserted.
- TIMEOUT=4, ready never asserted → BusErr pulses once in DONE after 4 BUSY cycles, then IDLE.
- Reset asserted in the second BUSY cycle → DMemReq and MemStall drop asynchronously; after Reset is released, a new load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
//   - Access size encodings as carried by MemSize_MEM
//   - FSM state encodings (IDLE / BUSY / DONE)
//   - Byte-enable patterns and the registered bus request record
//   - misaligned(): decode of accesses the bus cannot perform in one beat
package mem_pkg;

  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Bus-side write attributes captured when the access is launched.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } memReq_t;

  // Size 11 is reserved and always rejected.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addrLo);
    return ((size == MEM_WORD) && (addrLo != 2'b00)) ||
           ((size == MEM_HALF) && addrLo[0]) ||
           (size == 2'b11);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Multi-cycle data-memory bus: request/ready handshake.
//   DMemReq/DMemWe/DMemAddr/DMemBE/DMemWData : unit -> memory
//   DMemReady/DMemRData                      : memory -> unit (data valid with ready)
// master = access unit, slave = memory.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              DMemReq;
  logic              DMemWe;
  logic [ADDR_W-1:0] DMemAddr;
  logic [3:0]        DMemBE;
  logic [31:0]       DMemWData;
  logic              DMemReady;
  logic [31:0]       DMemRData;

  modport master (
    output DMemReq, DMemWe, DMemAddr, DMemBE, DMemWData,
    input  DMemReady, DMemRData
  );

  modport slave (
    input  DMemReq, DMemWe, DMemAddr, DMemBE, DMemWData,
    output DMemReady, DMemRData
  );
endinterface

// File: rtl/mem_load_align.sv
// Load formatter: picks the addressed byte/half lane out of a little-endian
// read word and sign- or zero-extends it. Word loads pass through.
//   rData    : raw bus word
//   addrLo   : byte offset within the word
//   size     : MEM_WORD / MEM_HALF / MEM_BYTE
//   isSigned : 1 = sign-extend
//   data     : formatted 32-bit result
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rData,
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] data
);

  logic [3:0][7:0] lanes;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;

  assign lanes   = rData;
  assign byteSel = lanes[addrLo];
  assign halfSel = addrLo[1] ? rData[31:16] : rData[15:0];

  always_comb begin
    data = rData;
    case (size)
      MEM_BYTE: data = {{24{isSigned & byteSel[7]}}, byteSel};
      MEM_HALF: data = {{16{isSigned & halfSel[15]}}, halfSel};
      default:  data = rData;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller. Launches one bus access per load/store,
// stalls the pipeline until it completes, and registers formatted load data
// for MEM/WB.
//   Clk, Reset            : clock, async active-low reset
//   MemRead/MemWrite/MemSize/MemSigned/Address/WriteData (_MEM) : EX/MEM access
//   dmem                  : data-memory bus (master side)
//   ReadDataFromMem_MEM   : last completed load result (held between loads)
//   MemStall              : freeze upstream stages and MEM/WB
//   MisalignExc           : rejected access (no bus cycle issued)
//   BusErr                : one-cycle pulse when an access times out
// Sequence: IDLE (launch) -> BUSY (wait for ready) -> DONE (pipeline advances).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic [1:0]        MemSize_MEM,
  input  logic              MemSigned_MEM,
  input  logic [ADDR_W-1:0] Address_MEM,
  input  logic [31:0]       WriteData_MEM,
  mem_access_unit_if.master dmem,
  output logic [31:0]       ReadDataFromMem_MEM,
  output logic              MemStall,
  output logic              MisalignExc,
  output logic              BusErr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              timedOut;
  logic [ADDR_W-1:0] reqAddr;
  memReq_t           req, reqNext;
  logic [1:0]        ldSize, ldLo;
  logic              ldSigned;
  logic [31:0]       ldData;

  logic valid, misal, busy, launch, timeoutHit;

  assign valid      = MemRead_MEM | MemWrite_MEM;
  assign misal      = misaligned(MemSize_MEM, Address_MEM[1:0]);
  assign busy       = (state == BUSY);
  assign launch     = (state == IDLE) & valid & ~misal;
  assign timeoutHit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  // Store lane steering; a store wins when both read and write are set.
  always_comb begin
    reqNext.we    = MemWrite_MEM;
    reqNext.be    = BE_WORD;
    reqNext.wdata = WriteData_MEM;
    case (MemSize_MEM)
      MEM_HALF: begin
        reqNext.be    = Address_MEM[1] ? BE_HALF_HI : BE_HALF_LO;
        reqNext.wdata = {2{WriteData_MEM[15:0]}};
      end
      MEM_BYTE: begin
        reqNext.be    = BE_BYTE0 << Address_MEM[1:0];
        reqNext.wdata = {4{WriteData_MEM[7:0]}};
      end
      default: ;
    endcase
  end

  mem_load_align uAlign (
    .rData    (dmem.DMemRData),
    .addrLo   (ldLo),
    .size     (ldSize),
    .isSigned (ldSigned),
    .data     (ldData)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      timedOut            <= 1'b0;
      reqAddr             <= '0;
      req                 <= '0;
      ldSize              <= MEM_WORD;
      ldLo                <= 2'b00;
      ldSigned            <= 1'b0;
      ReadDataFromMem_MEM <= '0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          reqAddr  <= {Address_MEM[ADDR_W-1:2], 2'b00};
          req      <= reqNext;
          ldSize   <= MemSize_MEM;
          ldLo     <= Address_MEM[1:0];
          ldSigned <= MemSigned_MEM;
          cnt      <= '0;
          timedOut <= 1'b0;
          state    <= BUSY;
        end
        BUSY: begin
          if (dmem.DMemReady) begin
            if (!req.we) ReadDataFromMem_MEM <= ldData;
            state <= DONE;
          end else if (timeoutHit) begin
            timedOut <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt      <= '0;
          timedOut <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs are only non-zero while the request is on the bus.
  assign dmem.DMemReq   = busy;
  assign dmem.DMemWe    = busy & req.we;
  assign dmem.DMemAddr  = busy ? reqAddr : '0;
  assign dmem.DMemBE    = busy ? req.be : 4'b0000;
  assign dmem.DMemWData = busy ? req.wdata : 32'h0;

  // Combinational flags are gated by Reset so every output is 0 while held in reset.
  assign MemStall    = Reset & (busy | launch);
  assign MisalignExc = Reset & (state == IDLE) & valid & misal;
  assign BusErr      = (state == DONE) & timedOut;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MemRead_MEM, MemWrite_MEM, MemSigned_MEM;
  logic [1:0]  MemSize_MEM;
  logic [31:0] Address_MEM, WriteData_MEM;
  logic [31:0] ReadDataFromMem_MEM;
  logic        MemStall, MisalignExc, BusErr;

  mem_access_unit_if #(.ADDR_W(32)) dmem ();

  mem_access_unit #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .MemRead_MEM         (MemRead_MEM),
    .MemWrite_MEM        (MemWrite_MEM),
    .MemSize_MEM         (MemSize_MEM),
    .MemSigned_MEM       (MemSigned_MEM),
    .Address_MEM         (Address_MEM),
    .WriteData_MEM       (WriteData_MEM),
    .dmem                (dmem),
    .ReadDataFromMem_MEM (ReadDataFromMem_MEM),
    .MemStall            (MemStall),
    .MisalignExc         (MisalignExc),
    .BusErr              (BusErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rd, wr, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wd, rdata;
    int          waits;
    logic        mis, err, keep, we;
    logic [31:0] eAddr;
    logic [3:0]  eBe;
    logic [31:0] eWd, eRes;
    int          eStall;
  } vec_t;

  vec_t        vecs[$];
  vec_t        expQ[$];
  int          nPass = 0, nTotal = 0;
  logic [31:0] modelRes;

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] size, logic sgn,
                              logic [31:0] addr, logic [31:0] wd, logic [31:0] rdata,
                              int waits, logic mis, logic err, logic keep, logic we,
                              logic [31:0] eAddr, logic [3:0] eBe, logic [31:0] eWd,
                              logic [31:0] eRes, int eStall);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wd = wd;
    v.rdata = rdata; v.waits = waits; v.mis = mis; v.err = err; v.keep = keep;
    v.we = we; v.eAddr = eAddr; v.eBe = eBe; v.eWd = eWd; v.eRes = eRes; v.eStall = eStall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTotal++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic clearInputs();
    MemRead_MEM = 0; MemWrite_MEM = 0; MemSize_MEM = MEM_WORD; MemSigned_MEM = 0;
    Address_MEM = '0; WriteData_MEM = '0;
  endtask

  task automatic runVec(input vec_t v, input int idx);
    vec_t        e;
    int          stall = 0, errs = 0, waitCnt = 0;
    logic        sawReq = 0, done = 0, busBad = 0;
    logic [31:0] bAddr = 0, bWd = 0;
    logic [3:0]  bBe = 0;
    logic        bWe = 0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(posedge Clk); #1;
    MemRead_MEM = v.rd; MemWrite_MEM = v.wr; MemSize_MEM = v.size; MemSigned_MEM = v.sgn;
    Address_MEM = v.addr; WriteData_MEM = v.wd;
    expQ.push_back(v);
    if (v.mis) begin
      @(negedge Clk);
      chk({tag, " misalign"}, {31'b0, MisalignExc}, 32'd1);
      chk({tag, " mis stall"}, {31'b0, MemStall}, 32'd0);
      @(posedge Clk); #1;
      @(negedge Clk);
      chk({tag, " mis noreq"}, {31'b0, dmem.DMemReq}, 32'd0);
      e = expQ.pop_front();
      chk({tag, " mis result"}, ReadDataFromMem_MEM, modelRes);
    end else begin
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
        @(negedge Clk);
        if (cyc == 0) chk({tag, " no misalign"}, {31'b0, MisalignExc}, 32'd0);
        if (MemStall) stall++;
        if (BusErr) errs++;
        if (dmem.DMemReq) begin
          if (!sawReq) begin
            bAddr = dmem.DMemAddr; bBe = dmem.DMemBE; bWd = dmem.DMemWData; bWe = dmem.DMemWe;
          end else if (dmem.DMemAddr !== bAddr || dmem.DMemBE !== bBe ||
                       dmem.DMemWData !== bWd || dmem.DMemWe !== bWe) busBad = 1;
          sawReq = 1;
        end else if (sawReq && !MemStall) done = 1;
        if (!done) begin
          @(posedge Clk); #1;
          if (dmem.DMemReq && waitCnt == v.waits) begin
            dmem.DMemReady = 1; dmem.DMemRData = v.rdata;
          end else begin
            dmem.DMemReady = 0;
            if (dmem.DMemReq) waitCnt++;
          end
        end
      end
      dmem.DMemReady = 0;
      chk({tag, " completed"}, {31'b0, done}, 32'd1);
      e = expQ.pop_front();
      if (!e.keep) modelRes = e.eRes;
      chk({tag, " addr"}, bAddr, e.eAddr);
      chk({tag, " be"}, {28'b0, bBe}, {28'b0, e.eBe});
      chk({tag, " wdata"}, bWd, e.eWd);
      chk({tag, " we"}, {31'b0, bWe}, {31'b0, e.we});
      chk({tag, " bus stable"}, {31'b0, busBad}, 32'd0);
      chk({tag, " stall cycles"}, 32'(stall), 32'(e.eStall));
      chk({tag, " buserr pulses"}, 32'(errs), {31'b0, e.err});
      chk({tag, " result"}, ReadDataFromMem_MEM, modelRes);
    end
    @(posedge Clk); #1;
    clearInputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rd wr size sgn addr wd rdata waits | mis err keep we eAddr eBe eWd eRes eStall
    vecs.push_back(mk(1,0,MEM_WORD,0,32'h100,0,32'hDEADBEEF,2, 0,0,0,0,32'h100,4'hF,0,32'hDEADBEEF,4));
    vecs.push_back(mk(1,0,MEM_BYTE,1,32'h103,0,32'h80FF0000,0, 0,0,0,0,32'h100,4'h8,0,32'hFFFFFF80,2));
    vecs.push_back(mk(1,0,MEM_BYTE,0,32'h103,0,32'h80FF0000,0, 0,0,0,0,32'h100,4'h8,0,32'h00000080,2));
    vecs.push_back(mk(0,1,MEM_HALF,0,32'h202,32'h1234ABCD,0,1, 0,0,1,1,32'h200,4'hC,32'hABCDABCD,0,3));
    vecs.push_back(mk(1,0,MEM_WORD,0,32'h101,0,0,0, 1,0,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,MEM_WORD,0,32'h300,0,32'h11111111,99, 0,1,1,0,32'h300,4'hF,0,0,5));
    vecs.push_back(mk(1,0,MEM_HALF,1,32'h102,0,32'h80011234,0, 0,0,0,0,32'h100,4'hC,0,32'hFFFF8001,2));
    vecs.push_back(mk(1,0,MEM_HALF,0,32'h100,0,32'h8001F234,0, 0,0,0,0,32'h100,4'h3,0,32'h0000F234,2));
    vecs.push_back(mk(0,1,MEM_BYTE,0,32'h401,32'h000000A5,0,0, 0,0,1,1,32'h400,4'h2,32'hA5A5A5A5,0,2));
    vecs.push_back(mk(1,0,MEM_HALF,0,32'h101,0,0,0, 1,0,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b11,0,32'h100,0,0,0, 1,0,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,MEM_WORD,0,32'h500,32'h11223344,0,3, 0,0,1,1,32'h500,4'hF,32'h11223344,0,5));
    vecs.push_back(mk(1,0,MEM_BYTE,1,32'h100,0,32'h1234567F,1, 0,0,0,0,32'h100,4'h1,0,32'h0000007F,3));

    // Reset state, with a pending access on the inputs.
    Reset = 0;
    clearInputs();
    MemRead_MEM = 1; Address_MEM = 32'h100;
    dmem.DMemReady = 0; dmem.DMemRData = '0;
    modelRes = '0;
    #3;
    chk("reset req", {31'b0, dmem.DMemReq}, 32'd0);
    chk("reset stall", {31'b0, MemStall}, 32'd0);
    chk("reset rdata", ReadDataFromMem_MEM, 32'h0);
    chk("reset buserr", {31'b0, BusErr}, 32'd0);
    clearInputs();
    @(negedge Clk); Reset = 1;

    foreach (vecs[i]) runVec(vecs[i], i);

    // Ready outside BUSY must not disturb anything.
    @(posedge Clk); #1;
    dmem.DMemReady = 1; dmem.DMemRData = 32'hFFFFFFFF;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("stray ready stall", {31'b0, MemStall}, 32'd0);
    chk("stray ready rdata", ReadDataFromMem_MEM, modelRes);
    dmem.DMemReady = 0;

    // Reset in the second BUSY cycle abandons the access asynchronously.
    @(posedge Clk); #1;
    MemRead_MEM = 1; MemSize_MEM = MEM_WORD; Address_MEM = 32'h700;
    @(posedge Clk); #1;
    chk("pre-reset busy req", {31'b0, dmem.DMemReq}, 32'd1);
    @(posedge Clk); #2;
    Reset = 0;
    #1;
    chk("async reset req", {31'b0, dmem.DMemReq}, 32'd0);
    chk("async reset stall", {31'b0, MemStall}, 32'd0);
    chk("async reset rdata", ReadDataFromMem_MEM, 32'h0);
    modelRes = '0;
    clearInputs();
    @(negedge Clk); Reset = 1;
    runVec(vecs[0], 100);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
